// File: rtl/ws2811_encoder_if.sv
// Word-stream handshake into the WS2811 encoder.
// A word moves when s_valid && s_ready.
interface ws2811_encoder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/ws2811_encoder.sv
// WS2811 single-wire encoder: serialises words into fixed-period bit cells.
// Each frame is followed by a low latch period.
module ws2811_encoder #(
    parameter int DATA_W    = 8,
    parameter int T_BIT     = 16,
    parameter int T0H       = 4,
    parameter int T1H       = 12,
    parameter int T_LATCH   = 640,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    ws2811_encoder_if.slave     s,
    output logic                dout,
    output logic                busy,
    output logic                underrun
);
    localparam int PW = $clog2(T_BIT);
    localparam int BW = $clog2(DATA_W);
    localparam int LW = $clog2(T_LATCH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]        r_state;
    logic [PW-1:0]     r_phase;
    logic [BW-1:0]     r_bit;
    logic [LW-1:0]     r_lcnt;
    logic [DATA_W-1:0] r_word;
    logic              r_last;
    logic              r_dout;

    logic [1:0]        w_state;
    logic [PW-1:0]     w_phase;
    logic [BW-1:0]     w_bit;
    logic [LW-1:0]     w_lcnt;
    logic [DATA_W-1:0] w_word;
    logic              w_last;
    logic              w_dout;
    logic              w_bitval;
    logic [PW-1:0]     w_hi;
    logic              w_cell_end;
    logic              w_word_end;
    logic              w_boundary;
    logic              w_load;

    assign w_cell_end = (r_state == S_SHIFT) && (r_phase == PW'(T_BIT - 1));
    assign w_word_end = w_cell_end && (r_bit == BW'(DATA_W - 1));
    assign w_boundary = w_word_end && !r_last;

    assign s.s_ready = (r_state == S_IDLE) || w_boundary;
    assign w_load    = s.s_valid && s.s_ready;
    assign underrun  = w_boundary && !s.s_valid && !rst;
    assign busy      = (r_state != S_IDLE);
    assign dout      = r_dout;

    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        w_bit   = r_bit;
        w_lcnt  = r_lcnt;
        w_word  = r_word;
        w_last  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state = S_SHIFT;
                    w_word  = s.s_data;
                    w_last  = s.s_last;
                    w_phase = '0;
                    w_bit   = '0;
                end
            end
            S_SHIFT: begin
                if (!w_cell_end) begin
                    w_phase = r_phase + 1'b1;
                end else begin
                    w_phase = '0;
                    if (!w_word_end) begin
                        w_bit = r_bit + 1'b1;
                        if (MSB_FIRST != 0)
                            w_word = {r_word[DATA_W-2:0], 1'b0};
                        else
                            w_word = {1'b0, r_word[DATA_W-1:1]};
                    end else if (w_load) begin
                        w_bit  = '0;
                        w_word = s.s_data;
                        w_last = s.s_last;
                    end else begin
                        w_state = S_LATCH;
                        w_bit   = '0;
                        w_lcnt  = '0;
                    end
                end
            end
            S_LATCH: begin
                if (r_lcnt == LW'(T_LATCH - 1)) begin
                    w_state = S_IDLE;
                    w_lcnt  = '0;
                end else begin
                    w_lcnt = r_lcnt + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // dout is registered from the next cell position so it rises one cycle after a transfer.
    assign w_bitval = (MSB_FIRST != 0) ? w_word[DATA_W-1] : w_word[0];
    assign w_hi     = w_bitval ? PW'(T1H) : PW'(T0H);
    assign w_dout   = (w_state == S_SHIFT) && (w_phase < w_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_lcnt  <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_phase <= w_phase;
            r_bit   <= w_bit;
            r_lcnt  <= w_lcnt;
            r_word  <= w_word;
            r_last  <= w_last;
            r_dout  <= w_dout;
        end
    end
endmodule

// File: tb/tb_ws2811_encoder.sv
// Directed and scoreboarded bench for ws2811_encoder (8-bit MSB-first and 24-bit LSB-first).
module tb_ws2811_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    ws2811_encoder_if #(.DATA_W(8))  bus8 ();
    ws2811_encoder_if #(.DATA_W(24)) bus24 ();

    logic dout8, busy8, under8;
    logic dout24, busy24, under24;

    ws2811_encoder #(.DATA_W(8), .MSB_FIRST(1)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .s        (bus8),
        .dout     (dout8),
        .busy     (busy8),
        .underrun (under8)
    );

    ws2811_encoder #(.DATA_W(24), .MSB_FIRST(0)) u_dut24 (
        .clk      (clk),
        .rst      (rst),
        .s        (bus24),
        .dout     (dout24),
        .busy     (busy24),
        .underrun (under24)
    );

    logic        rec_dout  [0:8191];
    logic        rec_busy  [0:8191];
    logic        rec_ready [0:8191];
    logic        rec_under [0:8191];
    logic [23:0] q_data [$];
    logic        q_last [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int sel);
        logic v;
        logic [23:0] d;
        logic l;
        v = (q_data.size() != 0);
        d = v ? q_data[0] : 24'h0;
        l = v ? q_last[0] : 1'b0;
        if (sel == 0) begin
            bus8.s_valid = v; bus8.s_data = d[7:0]; bus8.s_last = l;
        end else begin
            bus24.s_valid = v; bus24.s_data = d; bus24.s_last = l;
        end
    endtask

    // Cycle 0 of the record is the cycle of the first transfer.
    task automatic record(input int n, input int sel);
        logic xfer;
        present(sel);
        for (int c = 0; c < n; c++) begin
            rec_dout[c]  = (sel == 0) ? dout8 : dout24;
            rec_busy[c]  = (sel == 0) ? busy8 : busy24;
            rec_ready[c] = (sel == 0) ? bus8.s_ready : bus24.s_ready;
            rec_under[c] = (sel == 0) ? under8 : under24;
            xfer = (sel == 0) ? (bus8.s_valid && bus8.s_ready) : (bus24.s_valid && bus24.s_ready);
            tick;
            if (xfer) begin
                void'(q_data.pop_front());
                void'(q_last.pop_front());
                present(sel);
            end
        end
        bus8.s_valid = 1'b0;
        bus24.s_valid = 1'b0;
    endtask

    function automatic int cell_high(input int start);
        int h;
        h = 0;
        while (h < 16 && rec_dout[start+h] === 1'b1) h++;
        for (int p = h; p < 16; p++)
            if (rec_dout[start+p] !== 1'b0) return -1;
        return h;
    endfunction

    function automatic int first_idle(input int n);
        for (int c = 1; c < n; c++)
            if (rec_busy[c] === 1'b0) return c;
        return -1;
    endfunction

    task automatic test_reset;
        bus8.s_valid = 1'b0; bus8.s_data = '0; bus8.s_last = 1'b0;
        bus24.s_valid = 1'b0; bus24.s_data = '0; bus24.s_last = 1'b0;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        #1;
        checks++;
        if (dout8 !== 1'b0 || busy8 !== 1'b0 || under8 !== 1'b0 || bus8.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset8: dout=%b busy=%b under=%b ready=%b required 0 0 0 1", dout8, busy8, under8, bus8.s_ready);
        end
        checks++;
        if (dout24 !== 1'b0 || busy24 !== 1'b0 || bus24.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset24: dout=%b busy=%b ready=%b required 0 0 1", dout24, busy24, bus24.s_ready);
        end
    endtask

    task automatic test_single_word;
        int exp_hi [8] = '{12, 4, 12, 4, 4, 12, 4, 12};
        int h, bad, cnt, fall;
        q_data.push_back(24'hA5); q_last.push_back(1'b1);
        record(800, 0);
        checks++;
        if (rec_ready[0] !== 1'b1 || rec_dout[0] !== 1'b0) begin
            failures++;
            $display("FAIL idle_state: ready=%b dout=%b required 1 0", rec_ready[0], rec_dout[0]);
        end
        for (int k = 0; k < 8; k++) begin
            h = cell_high(1 + 16*k);
            checks++;
            if (h !== exp_hi[k]) begin
                failures++;
                $display("FAIL a5_cell%0d: high=%0d required %0d", k, h, exp_hi[k]);
            end
        end
        bad = 0;
        for (int c = 129; c <= 768; c++)
            if (rec_dout[c] !== 1'b0 || rec_busy[c] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL a5_latch: bad_cycles=%0d required 0", bad);
        end
        fall = first_idle(800);
        checks++;
        if (fall != 769) begin
            failures++;
            $display("FAIL a5_busy_fall: cycle=%0d required 769", fall);
        end
        cnt = 0;
        for (int c = 1; c <= 768; c++) cnt += (rec_ready[c] === 1'b1 || rec_under[c] === 1'b1) ? 1 : 0;
        checks++;
        if (cnt != 0) begin
            failures++;
            $display("FAIL a5_ready_under: pulses=%0d required 0", cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] exp;
        int h, bad, cnt, fall;
        exp = 24'hFF0081;
        q_data.push_back(24'hFF); q_last.push_back(1'b0);
        q_data.push_back(24'h00); q_last.push_back(1'b0);
        q_data.push_back(24'h81); q_last.push_back(1'b1);
        record(1100, 0);
        for (int w = 0; w < 3; w++) begin
            bad = 0;
            for (int k = 0; k < 8; k++) begin
                h = cell_high(1 + 16*(8*w + k));
                if (h !== (exp[23 - 8*w - k] ? 12 : 4)) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL b2b_word%0d: bad_cells=%0d required 0", w, bad);
            end
        end
        cnt = 0;
        for (int c = 1; c < 1100; c++) cnt += (rec_ready[c] === 1'b1 && rec_busy[c] === 1'b1) ? 1 : 0;
        checks++;
        if (cnt != 2 || rec_ready[128] !== 1'b1 || rec_ready[256] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: pulses=%0d at128=%b at256=%b required 2 1 1", cnt, rec_ready[128], rec_ready[256]);
        end
        cnt = 0;
        for (int c = 0; c < 1100; c++) cnt += (rec_under[c] === 1'b1) ? 1 : 0;
        checks++;
        if (cnt != 0 || q_data.size() != 0) begin
            failures++;
            $display("FAIL b2b_under: underruns=%0d left=%0d required 0 0", cnt, q_data.size());
        end
        fall = first_idle(1100);
        checks++;
        if (fall != 1025) begin
            failures++;
            $display("FAIL b2b_busy_fall: cycle=%0d required 1025", fall);
        end
    endtask

    task automatic test_underrun;
        logic [7:0] w;
        int h, bad, cnt, fall;
        w = 8'h3C;
        q_data.push_back(24'h3C); q_last.push_back(1'b0);
        record(800, 0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            h = cell_high(1 + 16*k);
            if (h !== (w[7-k] ? 12 : 4)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ur_cells: bad_cells=%0d required 0", bad);
        end
        cnt = 0;
        for (int c = 0; c < 800; c++) cnt += (rec_under[c] === 1'b1) ? 1 : 0;
        checks++;
        if (cnt != 1 || rec_under[128] !== 1'b1) begin
            failures++;
            $display("FAIL ur_pulse: count=%0d at128=%b required 1 1", cnt, rec_under[128]);
        end
        bad = 0;
        for (int c = 129; c <= 768; c++) if (rec_dout[c] !== 1'b0) bad++;
        fall = first_idle(800);
        checks++;
        if (bad != 0 || fall != 769) begin
            failures++;
            $display("FAIL ur_latch: high_cycles=%0d idle_at=%0d required 0 769", bad, fall);
        end
    endtask

    task automatic test_lsb_first_24;
        int h, bad, fall;
        q_data.push_back(24'h000001); q_last.push_back(1'b1);
        record(1100, 1);
        h = cell_high(1);
        checks++;
        if (h != 12) begin
            failures++;
            $display("FAIL lsb_first_cell: high=%0d required 12", h);
        end
        bad = 0;
        for (int k = 1; k < 24; k++) if (cell_high(1 + 16*k) != 4) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL lsb_rest_cells: bad_cells=%0d required 0", bad);
        end
        fall = first_idle(1100);
        checks++;
        if (fall != 1025) begin
            failures++;
            $display("FAIL lsb_busy_fall: cycle=%0d required 1025", fall);
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [7:0] w;
        int h, bad, fall;
        bus8.s_data = 8'h5A; bus8.s_last = 1'b1; bus8.s_valid = 1'b1;
        tick;
        bus8.s_valid = 1'b0;
        repeat (55) tick;
        checks++;
        if (dout8 !== 1'b1 || busy8 !== 1'b1) begin
            failures++;
            $display("FAIL mid_bit3_phase7: dout=%b busy=%b required 1 1", dout8, busy8);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (dout8 !== 1'b0 || busy8 !== 1'b0 || bus8.s_ready !== 1'b1 || under8 !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort: dout=%b busy=%b ready=%b under=%b required 0 0 1 0", dout8, busy8, bus8.s_ready, under8);
        end
        rst = 1'b1; bus8.s_data = 8'hFF; bus8.s_last = 1'b1; bus8.s_valid = 1'b1;
        tick;
        rst = 1'b0; bus8.s_valid = 1'b0;
        tick;
        checks++;
        if (dout8 !== 1'b0 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL rst_wins: dout=%b busy=%b required 0 0", dout8, busy8);
        end
        w = 8'hC3;
        q_data.push_back(24'hC3); q_last.push_back(1'b1);
        record(800, 0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            h = cell_high(1 + 16*k);
            if (h !== (w[7-k] ? 12 : 4)) bad++;
        end
        fall = first_idle(800);
        checks++;
        if (bad != 0 || fall != 769) begin
            failures++;
            $display("FAIL after_rst_word: bad_cells=%0d idle_at=%0d required 0 769", bad, fall);
        end
        bus8.s_data = 8'h0F; bus8.s_last = 1'b0; bus8.s_valid = 1'b1;
        tick;
        bus8.s_valid = 1'b0;
        repeat (127) tick;
        rst = 1'b1;
        #1;
        checks++;
        if (bus8.s_ready !== 1'b1 || under8 !== 1'b0) begin
            failures++;
            $display("FAIL rst_at_boundary: ready=%b under=%b required 1 0", bus8.s_ready, under8);
        end
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || under8 !== 1'b0) begin
            failures++;
            $display("FAIL rst_boundary_after: busy=%b under=%b required 0 0", busy8, under8);
        end
    endtask

    task automatic test_random;
        bit exp_bits [$];
        bit got_bits [$];
        int frames, nw, n, c, len, bad_len, bad_bits, longs;
        logic [7:0] d;
        frames = 5;
        n = 100;
        for (int f = 0; f < frames; f++) begin
            nw = $urandom_range(1, 3);
            n += 1 + 128*nw + 640;
            for (int w = 0; w < nw; w++) begin
                d = 8'($urandom_range(0, 255));
                q_data.push_back({16'h0, d});
                q_last.push_back(w == nw - 1);
                for (int k = 7; k >= 0; k--) exp_bits.push_back(d[k]);
            end
        end
        record(n, 0);
        c = 0; bad_len = 0; longs = 0;
        while (c < n) begin
            len = 0;
            if (rec_dout[c] === 1'b1) begin
                while (c < n && rec_dout[c] === 1'b1) begin len++; c++; end
                if (len == 12) got_bits.push_back(1'b1);
                else if (len == 4) got_bits.push_back(1'b0);
                else bad_len++;
            end else begin
                while (c < n && rec_dout[c] !== 1'b1) begin len++; c++; end
                if (len >= 640) longs++;
            end
        end
        checks++;
        if (got_bits.size() != exp_bits.size() || bad_len != 0) begin
            failures++;
            $display("FAIL rand_count: bits=%0d bad_len=%0d required %0d 0", got_bits.size(), bad_len, exp_bits.size());
        end
        bad_bits = 0;
        for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
            if (got_bits[i] != exp_bits[i]) bad_bits++;
        checks++;
        if (bad_bits != 0) begin
            failures++;
            $display("FAIL rand_bits: wrong_bits=%0d required 0", bad_bits);
        end
        checks++;
        if (longs != frames) begin
            failures++;
            $display("FAIL rand_gaps: long_gaps=%0d required %0d", longs, frames);
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_back_to_back;
        test_underrun;
        test_lsb_first_24;
        test_reset_mid_shift;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ws2811_encoder.md
WS2811_ENCODER -- requirements
Module: ws2811_encoder

Interface
REQ-001 Parameter DATA_W, default 8: bits per input word; 24 is also legal (one RGB pixel per word).
REQ-002 Parameter T_BIT, default 16: clk cycles per bit cell (1.25 us at 12.8 MHz).
REQ-003 Parameter T0H, default 4: high cycles for a '0' bit.
REQ-004 Parameter T1H, default 12: high cycles for a '1' bit.
REQ-005 Parameter T_LATCH, default 640: low cycles after a frame (50 us at 12.8 MHz).
REQ-006 Parameter MSB_FIRST, default 1: 1 sends bit DATA_W-1 first; 0 sends bit 0 first.
REQ-007 clk  input  1  single clock; all logic on posedge clk.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 s_data  input  DATA_W  word to serialise.
REQ-010 s_valid  input  1  s_data/s_last valid.
REQ-011 s_last  input  1  word is the final word of the frame.
REQ-012 s_ready  output  1  encoder accepts a word this cycle; a transfer occurs when s_valid && s_ready.
REQ-013 dout  output  1  WS2811 line, registered.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 underrun  output  1  one-cycle pulse on mid-frame data starvation.

Function
REQ-016 States SHALL be IDLE, SHIFT and LATCH; there SHALL be no other states.
REQ-017 Parameters SHALL satisfy 0 < T0H < T1H < T_BIT and T_LATCH >= 1; behaviour outside this range is undefined.
REQ-018 In IDLE, s_ready SHALL be 1 and dout SHALL be 0.
REQ-019 Transfer in IDLE: the block SHALL latch s_data and s_last, then enter SHIFT with bit index 0 and phase 0 on the next cycle; dout SHALL rise exactly 1 cycle after the transfer cycle.
REQ-020 In SHIFT, phase SHALL count 0..T_BIT-1 per bit.
REQ-021 In SHIFT, dout SHALL be 1 for phase < (current bit ? T1H : T0H) and 0 otherwise.
REQ-022 Bit order SHALL follow MSB_FIRST.
REQ-023 At phase T_BIT-1 of a non-final bit, the block SHALL advance to the next bit with phase 0.
REQ-024 At phase T_BIT-1 of bit DATA_W-1, if the latched s_last=0, s_ready SHALL be 1 for that cycle only.
REQ-025 If s_valid is high in that cycle, the new word SHALL be loaded and its bit 0 SHALL start the next cycle with no gap; frame cells SHALL be contiguous.
REQ-026 If s_valid is low in that cycle, underrun SHALL pulse for 1 cycle and the block SHALL enter LATCH, terminating the frame.
REQ-027 At phase T_BIT-1 of bit DATA_W-1 with latched s_last=1, the block SHALL enter LATCH; s_ready SHALL stay 0.
REQ-028 In LATCH, dout SHALL be 0 for exactly T_LATCH cycles, then the block SHALL return to IDLE; s_ready SHALL be 0 throughout LATCH.
REQ-029 Outside the cases in REQ-018 and REQ-024, s_ready SHALL be 0.
REQ-030 s_ready SHALL depend only on registered state, never on s_valid.
REQ-031 The phase counter SHALL be $clog2(T_BIT) bits wide, the latch counter $clog2(T_LATCH+1) bits wide and the bit index $clog2(DATA_W) bits wide; no counter SHALL wrap except phase at T_BIT-1.
REQ-032 Frame length SHALL be unlimited; frame end SHALL be set only by s_last or underrun.
REQ-033 The high time of every cell SHALL be exact; no cell SHALL be shortened or stretched at word boundaries.

Reset
REQ-034 With rst=1 at a posedge, on the next cycle: state=IDLE, dout=0, busy=0, underrun=0, counters=0 and latched word cleared.
REQ-035 Reset mid-SHIFT or mid-LATCH SHALL abort immediately; the word in flight SHALL be dropped and no underrun pulse SHALL be produced.
REQ-036 When rst and a transfer occur in the same cycle, rst SHALL win and the word SHALL be discarded.

Verification
REQ-037 Default parameters; send 0xA5 with s_last=1 -> dout high-times 12,4,12,4,4,12,4,12 at 16-cycle spacing; then 640 low cycles; busy falls at cycle 1+128+640 after the transfer.
REQ-038 Frame of 3 words (0xFF, 0x00, 0x81) with s_valid held high -> 24 contiguous cells, s_ready pulses exactly twice at word boundaries, no underrun.
REQ-039 Word 1 with s_last=0, then s_valid low -> underrun pulses exactly once at cycle 128 of the word, followed by 640 low cycles and return to IDLE.
REQ-040 MSB_FIRST=0, DATA_W=24, send 0x000001 -> the first cell is a '1' (12 high), the remaining 23 cells are '0'.
REQ-041 Assert rst at phase 7 of bit 3 -> dout=0, busy=0 and s_ready=1 on the next cycle; a new word is then encoded correctly.
REQ-042 Scoreboard over random traffic: decoded bits equal the sent bits; every low gap of at least T_LATCH cycles coincides with s_last or underrun.
